// File: rtl/demux5_pkg.sv
// demux5 shared definitions: channel count, selector width,
// channel index type and validity/round-robin helpers.
package demux5_pkg;

  localparam int NUM_CH = 5;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] ch_idx_t;

  localparam ch_idx_t SEL_INVALID_MIN = 3'd5;

  function automatic logic is_valid_ch(input ch_idx_t c);
    return c < SEL_INVALID_MIN;
  endfunction

  function automatic ch_idx_t next_ptr(input ch_idx_t p);
    return (p == ch_idx_t'(NUM_CH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/demux5_slot.sv
// demux5_slot: one-entry output register with load and drain.
// Ports: clk, reset, load, load_data, drain -> valid, data.
module demux5_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic         valid,
  output logic [W-1:0] data
);

  // A load wins over a drain so a same-cycle refill keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux5_rr.sv
// demux5_rr: 1-to-5 demux with round-robin or explicit routing.
// Ports: clk, reset, in_valid/in_ready/in_data, auto, s,
//   out_valid/out_ready/out_data[0:4]; drop_cnt when
//   DEMUX5_DROP_CNT_EN is defined. Targets 5..7 are dropped.
module demux5_rr
  import demux5_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              auto,
  input  logic [SEL_W-1:0]  s,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
`ifdef DEMUX5_DROP_CNT_EN
  output logic [7:0]        drop_cnt,
`endif
  output logic [W-1:0]      out_data [0:NUM_CH-1]
);

  ch_idx_t            rr_ptr;
  ch_idx_t            target;
  logic               tgt_ok;
  logic               busy;
  logic               accept;
  logic [NUM_CH-1:0]  load;
  logic [NUM_CH-1:0]  drain;

  // Target is "busy" only when its slot is full and not draining;
  // invalid targets are never busy so the item is consumed.
  always_comb begin
    target   = auto ? rr_ptr : ch_idx_t'(s);
    tgt_ok   = is_valid_ch(target);
    busy     = 1'b0;
    load     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tgt_ok && target == ch_idx_t'(i))
        busy = out_valid[i] & ~out_ready[i];
    end
    in_ready = ~reset & ~busy;
    accept   = in_valid & in_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && tgt_ok && target == ch_idx_t'(i))
        load[i] = 1'b1;
    end
  end

  assign drain = out_valid & out_ready;

  // Pointer moves only on round-robin accepts; it never skips.
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (accept && auto)
      rr_ptr <= next_ptr(rr_ptr);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux5_slot #(.W(W)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .load_data (in_data),
      .drain     (drain[i]),
      .valid     (out_valid[i]),
      .data      (out_data[i])
    );
  end

`ifdef DEMUX5_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_q;

  assign drop = accept & ~tgt_ok;

  always_ff @(posedge clk) begin
    if (reset)
      drop_q <= '0;
    else if (drop && drop_q != 8'hFF)
      drop_q <= drop_q + 8'd1;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_demux5_rr.sv
// tb_demux5_rr: table vectors, corner sequences and random
// traffic checked against a queue-free slot model of demux5_rr.
module tb_demux5_rr;
  import demux5_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         auto;
  logic [2:0]   s;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready;
  logic [W-1:0] out_data [0:4];
`ifdef DEMUX5_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  demux5_rr #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .auto      (auto),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DEMUX5_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  bit         mv [5];
  logic [7:0] md [5];
  int         mptr;
  int         mdrop;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    bit         rst;
    bit         au;
    logic [2:0] sel;
    logic [7:0] d;
    logic [4:0] ordy;
    bit         exp_rdy;
    int         exp_ch;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Compare every output to the model at negedge, then advance
  // the model by the rules for the coming rising edge.
  task automatic cycle();
    int         tgt;
    bit         rdy;
    bit         acc;
    logic [4:0] ev;
    @(negedge clk);
    tgt = auto ? mptr : int'(s);
    if (reset)         rdy = 1'b0;
    else if (tgt >= 5) rdy = 1'b1;
    else               rdy = !mv[tgt] || out_ready[tgt];
    chk("in_ready", in_ready, rdy);
    for (int i = 0; i < 5; i++) ev[i] = mv[i];
    chk("out_valid", out_valid, ev);
    for (int i = 0; i < 5; i++)
      chk($sformatf("out_data%0d", i), out_data[i], md[i]);
`ifdef DEMUX5_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, mdrop);
`endif
    acc = in_valid && rdy;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        mv[i] = 0;
        md[i] = '0;
      end
      mptr  = 0;
      mdrop = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (acc && tgt == i) begin
          mv[i] = 1;
          md[i] = in_data;
        end else if (mv[i] && out_ready[i]) begin
          mv[i] = 0;
        end
      end
      if (acc && tgt >= 5 && mdrop < 255) mdrop++;
      if (acc && auto) mptr = (mptr + 1) % 5;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    cycle();
    reset    = 1'b0;
  endtask

  task automatic send(input bit au, input logic [2:0] sel,
                      input logic [7:0] d);
    auto     = au;
    s        = sel;
    in_data  = d;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    auto      = 1'b1;
    s         = '0;
    out_ready = '0;
    for (int i = 0; i < 5; i++) begin
      mv[i] = 0;
      md[i] = '0;
    end
    mptr  = 0;
    mdrop = 0;
    @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;

    // Round-robin fan-out, then mixed auto/explicit routing.
    for (int i = 0; i < 7; i++)
      tbl[i] = '{i == 0, 1'b1, 3'd0, 8'h10 + 8'(i), 5'h1f, 1'b1, i % 5};
    tbl[7] = '{1'b1, 1'b1, 3'd0, 8'h20, 5'h1f, 1'b1, 0};
    tbl[8] = '{1'b0, 1'b0, 3'd4, 8'h21, 5'h1f, 1'b1, 4};
    tbl[9] = '{1'b0, 1'b1, 3'd0, 8'h22, 5'h1f, 1'b1, 1};

    for (int k = 0; k < 10; k++) begin
      if (tbl[k].rst) do_reset();
      auto      = tbl[k].au;
      s         = tbl[k].sel;
      in_data   = tbl[k].d;
      out_ready = tbl[k].ordy;
      in_valid  = 1'b1;
      #1;
      chk($sformatf("tbl%0d_rdy", k), in_ready, tbl[k].exp_rdy);
      cycle();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_v", k), out_valid[tbl[k].exp_ch], 1'b1);
      chk($sformatf("tbl%0d_d", k), out_data[tbl[k].exp_ch], tbl[k].d);
    end
    cycle();

    // Invalid targets are dropped and counted.
    do_reset();
    out_ready = '0;
    for (int i = 5; i < 8; i++) send(1'b0, 3'(i), 8'h40 + 8'(i));
    chk("drop_valid", out_valid, 5'b0);
`ifdef DEMUX5_DROP_CNT_EN
    chk("drop_cnt3", drop_cnt, 8'd3);
    for (int i = 0; i < 300; i++) send(1'b0, 3'd7, 8'(i));
    chk("drop_sat", drop_cnt, 8'd255);
`endif

    // Explicit target held full, released with same-cycle refill.
    do_reset();
    out_ready = '0;
    send(1'b0, 3'd2, 8'hAA);
    chk("hold_aa", out_data[2], 8'hAA);
    auto     = 1'b0;
    s        = 3'd2;
    in_data  = 8'hBB;
    in_valid = 1'b1;
    #1;
    chk("stall_bb", in_ready, 1'b0);
    cycle();
    chk("still_aa", out_data[2], 8'hAA);
    out_ready[2] = 1'b1;
    #1;
    chk("accept_bb", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("bb_valid", out_valid[2], 1'b1);
    chk("bb_data", out_data[2], 8'hBB);
    cycle();
    chk("bb_drained", out_valid[2], 1'b0);

    // Round-robin stall does not skip to a free channel.
    do_reset();
    out_ready = '0;
    for (int i = 0; i < 5; i++) send(1'b1, 3'd0, 8'h50 + 8'(i));
    chk("all_full", out_valid, 5'h1f);
    auto     = 1'b1;
    in_data  = 8'h55;
    in_valid = 1'b1;
    #1;
    chk("rr_stall", in_ready, 1'b0);
    cycle();
    cycle();
    out_ready[0] = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("ch0_new", out_data[0], 8'h55);
    chk("ch1_old", out_data[1], 8'h51);
    out_ready = '0;
    in_data   = 8'h56;
    in_valid  = 1'b1;
    #1;
    chk("ptr1_stall", in_ready, 1'b0);
    out_ready[1] = 1'b1;
    cycle();
    in_valid  = 1'b0;
    out_ready = '0;
    chk("ch1_new", out_data[1], 8'h56);

    // Reset mid-traffic clears slots and pointer.
    do_reset();
    out_ready = '0;
    for (int i = 0; i < 3; i++) send(1'b1, 3'd0, 8'h60 + 8'(i));
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h70;
    #1;
    chk("rst_rdy", in_ready, 1'b0);
    cycle();
    chk("rst_valid", out_valid, 5'b0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rst_data%0d", i), out_data[i], 8'h00);
    reset     = 1'b0;
    out_ready = 5'h1f;
    send(1'b1, 3'd0, 8'h71);
    chk("post_rst_ch0", out_data[0], 8'h71);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      auto      = $urandom_range(0, 1);
      s         = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = 5'($urandom);
      cycle();
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux5_rr.md
DEMUX5_RR -- requirements
Module: demux5_rr

Interface
- REQ-001: The module SHALL have parameter W, default 8, giving the data width in bits.
- REQ-002: Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: Port reset, input, 1 bit: synchronous, active-high reset.
- REQ-004: Port in_valid, input, 1 bit: upstream item present.
- REQ-005: Port in_ready, output, 1 bit: block accepts the item this cycle.
- REQ-006: Port in_data, input, W bits: upstream item.
- REQ-007: Port auto, input, 1 bit: 1 = round-robin routing, 0 = explicit routing by s.
- REQ-008: Port s, input, 3 bits: explicit target channel.
- REQ-009: Port out_valid, output, 5 bits: per-channel item held.
- REQ-010: Port out_ready, input, 5 bits: per-channel consumer accepts.
- REQ-011: Port out_data, output, 5 x W bits (unpacked [0:4]): per-channel held item.

Function
- REQ-012: The target SHALL be rr_ptr when auto=1, else s; a target of 5, 6 or 7 SHALL be invalid.
- REQ-013: in_ready SHALL be combinational: 1 if target invalid, or !out_valid[target], or out_ready[target]; forced 0 while reset=1.
- REQ-014: An accept occurs when in_valid & in_ready; a channel delivery occurs when out_valid[i] & out_ready[i].
- REQ-015: An accept to a valid target SHALL load in_data into that channel's slot, with out_valid high from the next cycle (latency 1).
- REQ-016: An accept to an invalid target SHALL consume the item and not deliver it (drop).
- REQ-017: A slot with a delivery and no load SHALL clear out_valid next cycle; out_data holds its last value.
- REQ-018: Simultaneous delivery and load on one channel SHALL leave out_valid=1 with the new data; no bubble, no loss.
- REQ-019: Non-target channels SHALL be unaffected by an accept.
- REQ-020: rr_ptr SHALL advance by 1 on each accept while auto=1, wrapping 4->0, and SHALL hold otherwise, including while auto=0.
- REQ-021: With auto=1, in_ready=0 (target full, not draining) SHALL stall; the pointer SHALL NOT skip to a free channel.
- REQ-022: out_valid and out_data SHALL be driven only from registers.

Reset
- REQ-023: While reset=1, out_valid=0, all out_data=0, rr_ptr=0 and the drop counter=0; in-flight slot contents SHALL be discarded.
- REQ-024: The first accept after reset is deasserted SHALL route to channel 0 when auto=1.

Configuration
- REQ-025: With DEMUX5_DROP_CNT_EN defined, the module SHALL add output drop_cnt, 8 bits: the count of dropped items, incremented on each REQ-016 drop and saturating at 255.
- REQ-026: Without DEMUX5_DROP_CNT_EN, port drop_cnt and its counter SHALL be absent; drops SHALL behave identically.

Structure
- REQ-027: Package demux5_pkg SHALL hold NUM_CH=5, SEL_W=3, typedef ch_idx_t (logic [2:0]) and constant SEL_INVALID_MIN=5.
- REQ-028: Each channel slot SHALL be an instance of sub-module demux5_slot (one-entry register with load/drain, W-parameterised), instantiated 5 times.

Verification
- REQ-029: Reset, then auto=1, out_ready=5'b11111, 7 items 0x10..0x16 -> channels 0,1,2,3,4,0,1 each get one item one cycle after accept; in_ready stays 1.
- REQ-030: auto=0, s=5, 6, 7 with 3 items, macro on -> out_valid stays 0, in_ready=1, drop_cnt=3; 300 drops -> drop_cnt=255.
- REQ-031: auto=0, s=2, out_ready[2]=0, send 0xAA then 0xBB -> 0xAA held and in_ready=0 for 0xBB; raise out_ready[2] -> same cycle 0xBB accepted, next cycle out_data[2]=0xBB with out_valid[2]=1 continuous.
- REQ-032: auto=1, out_ready=0, send 5 items -> all slots full; 6th item stalls with rr_ptr=0; set out_ready[0]=1 -> 6th accepted into channel 0, rr_ptr=1.
- REQ-033: Reset asserted with 3 slots full and rr_ptr=3 -> next cycle out_valid=0, out_data all 0, rr_ptr=0, in_ready=0 during reset.
- REQ-034: Alternate auto=1 (accept to ch0), auto=0 s=4 (accept), auto=1 -> third item goes to ch1 (pointer unchanged by the explicit accept).
